// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU widths and divider special-case constants
package alu_pkg;
   localparam int WIDTH = 32;
   localparam logic [WIDTH-1:0] DIV0_QUOT = '1;
   localparam logic [WIDTH-1:0] INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
endpackage

// File: rtl/div_core_u32.sv
// div_core_u32: combinational unsigned restoring array divider, one shift/trial-subtract/select per stage
module div_core_u32
   import alu_pkg::*;
(
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder
);
   for (genvar i = 0; i < WIDTH; i++) begin : g_s
      logic [WIDTH-1:0] p, r;
      logic [WIDTH:0] t, d;
      if (i == 0) begin : g_first
         assign p = '0;
      end else begin : g_next
         assign p = g_s[i-1].r;
      end
      // partial remainder stays below divisor, so the 33-bit trial value never overflows
      assign t = {p, dividend[WIDTH-1-i]};
      assign d = t - {1'b0, divisor};
      assign quotient[WIDTH-1-i] = ~d[WIDTH];
      assign r = d[WIDTH] ? t[WIDTH-1:0] : d[WIDTH-1:0];
   end
   assign remainder = g_s[WIDTH-1].r;
endmodule

// File: rtl/div.sv
// div: signed truncating divider, combinational array core with registered quotient/remainder
module div
   import alu_pkg::*;
(
   input  logic             clk,
   input  logic             clr,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] res,
   output logic [WIDTH-1:0] rem
);
   logic sa, sb, dz, ovf;
   logic [WIDTH-1:0] ua, ub, q, r, nres, nrem;
   assign sa = a[WIDTH-1];
   assign sb = b[WIDTH-1];
   // negating INT_MIN yields 32'h80000000, which is exactly its unsigned magnitude
   assign ua = sa ? -a : a;
   assign ub = sb ? -b : b;
   assign dz = b == '0;
   assign ovf = a == INT_MIN && b == '1;
   div_core_u32 u_core (
      .dividend (ua),
      .divisor  (ub),
      .quotient (q),
      .remainder(r)
   );
   always_comb begin
      nres = dz ? DIV0_QUOT : ovf ? INT_MIN : (sa ^ sb) ? -q : q;
      nrem = dz ? a : ovf ? '0 : sa ? -r : r;
   end
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         res <= '0;
         rem <= '0;
      end else begin
         res <= nres;
         rem <= nrem;
      end
   end
endmodule

// File: tb/tb_div.sv
// tb_div: directed and random self-checking bench for the signed divider
module tb_div;
   logic clk = 1'b0;
   logic clr = 1'b0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic [31:0] res, rem;
   int n_cmp = 0;
   int n_bad = 0;

   div dut (.clk(clk), .clr(clr), .a(a), .b(b), .res(res), .rem(rem));

   always #10 clk = ~clk;

   task automatic step(input logic [31:0] x, input logic [31:0] y);
      a = x;
      b = y;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      #1;
      a = 32'd100;
      b = 32'd7;
      clr = 1'b1;
      #1;
      n_cmp++;
      if (res !== 32'd0 || rem !== 32'd0) begin
         n_bad++;
         $display("FAIL reset_async: res=%h rem=%h want 0 0", res, rem);
      end
      #3 clr = 1'b0;
      @(posedge clk);
      #1;
      n_cmp++;
      if (res !== 32'd14 || rem !== 32'd2) begin
         n_bad++;
         $display("FAIL reset_release: res=%0d rem=%0d want 14 2", $signed(res), $signed(rem));
      end
   endtask

   task automatic test_reset_mid;
      step(32'd50, 32'd3);
      a = 32'd90;
      b = 32'd4;
      #3 clr = 1'b1;
      #1;
      n_cmp++;
      if (res !== 32'd0 || rem !== 32'd0) begin
         n_bad++;
         $display("FAIL reset_mid: res=%h rem=%h want 0 0", res, rem);
      end
      #2 clr = 1'b0;
      @(posedge clk);
      #1;
      n_cmp++;
      if (res !== 32'd22 || rem !== 32'd2) begin
         n_bad++;
         $display("FAIL reset_mid_release: res=%0d rem=%0d want 22 2", $signed(res), $signed(rem));
      end
   endtask

   task automatic test_vectors(input string name, input logic [31:0] va[], input logic [31:0] vb[],
                               input logic [31:0] eq[], input logic [31:0] er[]);
      for (int i = 0; i < va.size(); i++) begin
         step(va[i], vb[i]);
         n_cmp++;
         if (res !== eq[i] || rem !== er[i]) begin
            n_bad++;
            $display("FAIL %s[%0d]: %h/%h got res=%h rem=%h want res=%h rem=%h",
                     name, i, va[i], vb[i], res, rem, eq[i], er[i]);
         end
      end
   endtask

   task automatic test_signs;
      test_vectors("signs", '{32'd7, -32'sd7, 32'd7, -32'sd7}, '{32'd2, 32'd2, -32'sd2, -32'sd2},
                   '{32'd3, -32'sd3, -32'sd3, 32'd3}, '{32'd1, -32'sd1, 32'd1, -32'sd1});
   endtask

   task automatic test_extremes;
      test_vectors("extremes", '{32'h80000000, 32'h80000000, 32'h7FFFFFFF},
                   '{32'hFFFFFFFF, 32'd1, 32'h80000000},
                   '{32'h80000000, 32'h80000000, 32'd0}, '{32'd0, 32'd0, 32'h7FFFFFFF});
   endtask

   task automatic test_div0;
      test_vectors("div0", '{32'd12345, 32'd0, 32'hFFFFFFF9}, '{32'd0, 32'd0, 32'd0},
                   '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF}, '{32'd12345, 32'd0, 32'hFFFFFFF9});
   endtask

   task automatic test_back_to_back;
      test_vectors("b2b", '{32'd100, -32'sd100, 32'd13, -32'sd1, 32'd0, 32'h7FFFFFFF},
                   '{32'd9, 32'd9, -32'sd4, 32'd1, 32'd5, 32'hFFFFFFFF},
                   '{32'd11, -32'sd11, -32'sd3, -32'sd1, 32'd0, 32'h80000001},
                   '{32'd1, -32'sd1, 32'd1, 32'd0, 32'd0, 32'd0});
   endtask

   task automatic test_random;
      logic signed [31:0] x, y, eq, er;
      for (int i = 0; i < 10000; i++) begin
         x = $urandom;
         y = (i % 4 == 0) ? $signed($urandom_range(0, 40)) - 20 : $urandom;
         if (y == 0 || (x == 32'sh80000000 && y == -1)) y = 32'sd3;
         eq = x / y;
         er = x % y;
         step(x, y);
         n_cmp++;
         if (res !== eq || rem !== er) begin
            n_bad++;
            $display("FAIL random[%0d]: %0d/%0d got res=%0d rem=%0d want res=%0d rem=%0d",
                     i, x, y, $signed(res), $signed(rem), eq, er);
            break;
         end
      end
   endtask

   initial begin
      test_reset;
      test_signs;
      test_extremes;
      test_div0;
      test_reset_mid;
      test_back_to_back;
      test_random;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
